// File: rtl/ext_bus_bridge.sv
// Bridge from the CPU split read/write ports to the 8-bit multiplexed external bus:
// address bytes go out MSB first under one-hot strobes, then one data byte per enabled lane.
module ext_bus_bridge #(
    parameter int RV   = 16,
    parameter int AW   = 16,
    parameter int WAIT = 0,
    localparam int NL  = RV / 8,
    localparam int LB  = $clog2(NL),
    localparam int NA  = AW / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [AW-LB-1:0] raddr,
    input  logic [NL-1:0]    rreq,
    output logic [RV-1:0]    rdata,
    output logic             rdone,
    input  logic [AW-LB-1:0] waddr,
    input  logic [NL-1:0]    wmask,
    input  logic [RV-1:0]    wdata,
    output logic             wdone,
    output logic [7:0]       pad_out,
    input  logic [7:0]       pad_in,
    output logic [NA-1:0]    latch,
    output logic             write,
    output logic [LB-1:0]    lane,
    input  logic             bus_wait
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t          state;
    logic            op_write;
    logic [AW-1:0]   addr_sh;
    logic [NL-1:0]   pend;
    logic [RV-1:0]   wdata_q;
    logic [2:0]      wcnt;
    logic [LB-1:0]   next_lane;
    logic [AW-1:0]   wbyte_addr;
    logic [AW-1:0]   rbyte_addr;

    assign wbyte_addr = {waddr, {LB{1'b0}}};
    assign rbyte_addr = {raddr, {LB{1'b0}}};

    // Lowest lane still pending; lanes are retired from pend as each beat starts.
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        next_lane = '0;
        for (int i = NL - 1; i >= 0; i--)
            if (pend[i]) next_lane = LB'(i);
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_write <= 1'b0;
            addr_sh  <= '0;
            pend     <= '0;
            wdata_q  <= '0;
            wcnt     <= '0;
            pad_out  <= '0;
            latch    <= '0;
            write    <= 1'b0;
            lane     <= '0;
            rdata    <= '0;
            rdone    <= 1'b0;
            wdone    <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (|wmask) begin
                        op_write <= 1'b1;
                        pend     <= wmask;
                        wdata_q  <= wdata;
                        pad_out  <= wbyte_addr[AW-1 -: 8];
                        addr_sh  <= wbyte_addr << 8;
                        latch    <= NA'(1) << (NA - 1);
                        state    <= ADDR;
                    end else if (|rreq) begin
                        op_write <= 1'b0;
                        pend     <= rreq;
                        rdata    <= '0;
                        pad_out  <= rbyte_addr[AW-1 -: 8];
                        addr_sh  <= rbyte_addr << 8;
                        latch    <= NA'(1) << (NA - 1);
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (latch[0]) begin
                        latch <= '0;
                        lane  <= next_lane;
                        pend  <= pend & ~(NL'(1) << next_lane);
                        wcnt  <= '0;
                        write <= op_write;
                        if (op_write) pad_out <= wdata_q[8*next_lane +: 8];
                        state <= DATA;
                    end else begin
                        latch   <= latch >> 1;
                        pad_out <= addr_sh[AW-1 -: 8];
                        addr_sh <= addr_sh << 8;
                    end
                end
                DATA: begin
                    // The final cycle of a beat repeats for as long as bus_wait is high.
                    if (wcnt != 3'(WAIT)) begin
                        wcnt <= wcnt + 3'd1;
                    end else if (!bus_wait) begin
                        if (!op_write) rdata[8*lane +: 8] <= pad_in;
                        if (|pend) begin
                            lane  <= next_lane;
                            pend  <= pend & ~(NL'(1) << next_lane);
                            wcnt  <= '0;
                            write <= op_write;
                            if (op_write) pad_out <= wdata_q[8*next_lane +: 8];
                        end else begin
                            write <= 1'b0;
                            rdone <= !op_write;
                            wdone <= op_write;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    rdone <= 1'b0;
                    wdone <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Scoreboard bench for ext_bus_bridge: a 16-bit/16-bit/no-wait instance and a
// 32-bit/24-bit/WAIT=2 instance, each transaction expanded into expected bus cycles.
module tb_ext_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ena, bus_wait;
    logic [7:0] pad_in;

    logic [14:0] raddr16, waddr16;
    logic [1:0]  rreq16, wmask16, latch16;
    logic [15:0] wdata16, rdata16;
    logic        rdone16, wdone16, write16, lane16;
    logic [7:0]  pad16;

    logic [21:0] raddr32, waddr32;
    logic [3:0]  rreq32, wmask32;
    logic [31:0] wdata32, rdata32;
    logic        rdone32, wdone32, write32;
    logic [2:0]  latch32;
    logic [1:0]  lane32;
    logic [7:0]  pad32;

    ext_bus_bridge #(.RV(16), .AW(16), .WAIT(0)) dut16 (
        .clk(clk), .reset(reset), .ena(ena),
        .raddr(raddr16), .rreq(rreq16), .rdata(rdata16), .rdone(rdone16),
        .waddr(waddr16), .wmask(wmask16), .wdata(wdata16), .wdone(wdone16),
        .pad_out(pad16), .pad_in(pad_in), .latch(latch16), .write(write16),
        .lane(lane16), .bus_wait(bus_wait)
    );

    ext_bus_bridge #(.RV(32), .AW(24), .WAIT(2)) dut32 (
        .clk(clk), .reset(reset), .ena(ena),
        .raddr(raddr32), .rreq(rreq32), .rdata(rdata32), .rdone(rdone32),
        .waddr(waddr32), .wmask(wmask32), .wdata(wdata32), .wdone(wdone32),
        .pad_out(pad32), .pad_in(pad_in), .latch(latch32), .write(write32),
        .lane(lane32), .bus_wait(bus_wait)
    );

    // One expected bus cycle plus the inputs the bench drives during that cycle.
    typedef struct {
        logic [2:0]  latch;
        logic [7:0]  pad;
        logic        write;
        logic [1:0]  lane;
        logic        rdone;
        logic        wdone;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [7:0]  pin;
        logic        bw;
        logic        ena;
        logic        rst;
        logic        drop_w;
        logic        drop_r;
    } cyc_t;

    cyc_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] last_lane[2];
    logic [7:0] last_pad[2];

    function automatic cyc_t held(input bit sel);
        cyc_t it;
        it       = '{default: '0};
        it.lane  = last_lane[sel];
        it.pad   = last_pad[sel];
        it.ena   = 1'b1;
        return it;
    endfunction

    // Model: expand one transaction into its expected cycles, starting the cycle after capture.
    task automatic push_txn(input bit sel, input bit is_w, input logic [31:0] word_addr,
                            input logic [3:0] mask, input logic [31:0] wd, input logic [31:0] rd,
                            input int wait_beat, input int wait_cyc, input bit drop_w, input bit drop_r);
        int          na, nl, lb, wt, b, nc;
        logic [31:0] baddr, rexp;
        cyc_t        it;
        na    = sel ? 3 : 2;
        nl    = sel ? 4 : 2;
        lb    = sel ? 2 : 1;
        wt    = sel ? 2 : 0;
        baddr = word_addr << lb;
        for (int j = 0; j < na; j++) begin
            it       = held(sel);
            it.latch = 3'(1 << (na - 1 - j));
            it.pad   = 8'(baddr >> (8 * (na - 1 - j)));
            q.push_back(it);
        end
        last_pad[sel] = baddr[7:0];
        rexp = '0;
        b    = 0;
        for (int i = 0; i < nl; i++) begin
            if (mask[i]) begin
                nc = 1 + wt + ((b == wait_beat) ? wait_cyc : 0);
                for (int c = 0; c < nc; c++) begin
                    it       = held(sel);
                    it.write = is_w;
                    it.lane  = 2'(i);
                    it.pad   = is_w ? 8'(wd >> (8 * i)) : last_pad[sel];
                    it.bw    = (c >= wt) && (c < nc - 1);
                    it.pin   = (c == nc - 1) ? 8'(rd >> (8 * i)) : 8'hC3;
                    q.push_back(it);
                end
                if (is_w) last_pad[sel] = 8'(wd >> (8 * i));
                last_lane[sel] = 2'(i);
                rexp = rexp | (rd & (32'hFF << (8 * i)));
                b++;
            end
        end
        it        = held(sel);
        it.rdone  = !is_w;
        it.wdone  = is_w;
        it.chk_rd = !is_w;
        it.rdata  = rexp;
        it.drop_w = drop_w;
        it.drop_r = drop_r;
        q.push_back(it);
    endtask

    task automatic push_idle(input bit sel, input int n);
        for (int k = 0; k < n; k++) q.push_back(held(sel));
    endtask

    // Pop one expected cycle per clock, compare it against the DUT, then drive that cycle's inputs.
    task automatic drain(input bit sel, input string tag);
        cyc_t        it;
        int          k;
        logic [2:0]  o_latch;
        logic [7:0]  o_pad;
        logic [1:0]  o_lane;
        logic [31:0] o_rdata;
        logic        o_write, o_rdone, o_wdone;
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            k++;
            it      = q.pop_front();
            o_latch = sel ? latch32 : {1'b0, latch16};
            o_pad   = sel ? pad32 : pad16;
            o_lane  = sel ? lane32 : {1'b0, lane16};
            o_rdata = sel ? rdata32 : {16'h0, rdata16};
            o_write = sel ? write32 : write16;
            o_rdone = sel ? rdone32 : rdone16;
            o_wdone = sel ? wdone32 : wdone16;
            checks++;
            if (o_latch !== it.latch) begin
                failures++;
                $display("FAIL %s cyc%0d latch got=%b exp=%b", tag, k, o_latch, it.latch);
            end
            checks++;
            if (o_pad !== it.pad) begin
                failures++;
                $display("FAIL %s cyc%0d pad_out got=%h exp=%h", tag, k, o_pad, it.pad);
            end
            checks++;
            if (o_write !== it.write) begin
                failures++;
                $display("FAIL %s cyc%0d write got=%b exp=%b", tag, k, o_write, it.write);
            end
            checks++;
            if (o_lane !== it.lane) begin
                failures++;
                $display("FAIL %s cyc%0d lane got=%0d exp=%0d", tag, k, o_lane, it.lane);
            end
            checks++;
            if ({o_rdone, o_wdone} !== {it.rdone, it.wdone}) begin
                failures++;
                $display("FAIL %s cyc%0d rdone/wdone got=%b%b exp=%b%b", tag, k,
                         o_rdone, o_wdone, it.rdone, it.wdone);
            end
            if (it.chk_rd) begin
                checks++;
                if (o_rdata !== it.rdata) begin
                    failures++;
                    $display("FAIL %s cyc%0d rdata got=%h exp=%h", tag, k, o_rdata, it.rdata);
                end
            end
            ena      = it.ena;
            reset    = it.rst;
            pad_in   = it.pin;
            bus_wait = it.bw;
            if (it.drop_w) begin
                wmask16 = '0;
                wmask32 = '0;
            end
            if (it.drop_r) begin
                rreq16 = '0;
                rreq32 = '0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ena = 1'b1; bus_wait = 1'b0; pad_in = 8'h00;
        rreq16 = '0; wmask16 = '0; raddr16 = '0; waddr16 = '0; wdata16 = '0;
        rreq32 = '0; wmask32 = '0; raddr32 = '0; waddr32 = '0; wdata32 = '0;
        for (int s = 0; s < 2; s++) begin
            last_lane[s] = '0;
            last_pad[s]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pad16, latch16, write16, lane16, rdone16, wdone16} !== 14'h0) begin
            failures++;
            $display("FAIL reset16 ctrl got=%h exp=0", {pad16, latch16, write16, lane16, rdone16, wdone16});
        end
        checks++;
        if (rdata16 !== 16'h0) begin
            failures++;
            $display("FAIL reset16 rdata got=%h exp=0", rdata16);
        end
        checks++;
        if ({pad32, latch32, write32, lane32, rdone32, wdone32} !== 16'h0) begin
            failures++;
            $display("FAIL reset32 ctrl got=%h exp=0", {pad32, latch32, write32, lane32, rdone32, wdone32});
        end
        checks++;
        if (rdata32 !== 32'h0) begin
            failures++;
            $display("FAIL reset32 rdata got=%h exp=0", rdata32);
        end
        reset = 1'b0;
    endtask

    task automatic test_write16;
        @(negedge clk);
        waddr16 = 15'h1234; wmask16 = 2'b11; wdata16 = 16'hBEEF;
        push_txn(1'b0, 1'b1, 32'h1234, 4'b0011, 32'hBEEF, 32'h0, -1, 0, 1'b1, 1'b0);
        push_idle(1'b0, 1);
        drain(1'b0, "write16");
    endtask

    task automatic test_read16;
        @(negedge clk);
        raddr16 = 15'h0010; rreq16 = 2'b10;
        push_txn(1'b0, 1'b0, 32'h0010, 4'b0010, 32'h0, 32'h5A00, -1, 0, 1'b0, 1'b1);
        push_idle(1'b0, 2);
        drain(1'b0, "read16");
    endtask

    task automatic test_wide_wait;
        @(negedge clk);
        waddr32 = 22'h12345; wmask32 = 4'b1010; wdata32 = 32'h11223344;
        push_txn(1'b1, 1'b1, 32'h12345, 4'b1010, 32'h11223344, 32'h0, -1, 0, 1'b1, 1'b0);
        push_idle(1'b1, 1);
        drain(1'b1, "write32");
        @(negedge clk);
        raddr32 = 22'h00ABC; rreq32 = 4'b0110;
        push_txn(1'b1, 1'b0, 32'h00ABC, 4'b0110, 32'h0, 32'h00A55A00, 1, 1, 1'b0, 1'b1);
        push_idle(1'b1, 1);
        drain(1'b1, "read32_mid");
        @(negedge clk);
        raddr32 = 22'h3F001; rreq32 = 4'b1001;
        push_txn(1'b1, 1'b0, 32'h3F001, 4'b1001, 32'h0, 32'h77000088, -1, 0, 1'b0, 1'b1);
        push_idle(1'b1, 1);
        drain(1'b1, "read32_edge");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        waddr16 = 15'h0100; wmask16 = 2'b01; wdata16 = 16'h00C7;
        raddr16 = 15'h0200; rreq16 = 2'b01;
        push_txn(1'b0, 1'b1, 32'h0100, 4'b0001, 32'h00C7, 32'h0, -1, 0, 1'b1, 1'b0);
        push_idle(1'b0, 1);
        push_txn(1'b0, 1'b0, 32'h0200, 4'b0001, 32'h0, 32'h003C, 0, 2, 1'b0, 1'b1);
        push_idle(1'b0, 2);
        drain(1'b0, "b2b_wait");
    endtask

    task automatic test_ena_freeze;
        cyc_t frz, orig;
        @(negedge clk);
        waddr16 = 15'h0ABC; wmask16 = 2'b10; wdata16 = 16'h9900;
        push_txn(1'b0, 1'b1, 32'h0ABC, 4'b0010, 32'h9900, 32'h0, -1, 0, 1'b1, 1'b0);
        push_idle(1'b0, 1);
        orig     = q[0];
        frz      = orig;
        frz.ena  = 1'b0;
        q[0]     = frz;
        q.insert(1, frz);
        q.insert(1, frz);
        q.insert(3, orig);
        drain(1'b0, "ena_freeze");
    endtask

    task automatic test_reset_mid;
        cyc_t it;
        @(negedge clk);
        waddr16 = 15'h0777; wmask16 = 2'b11; wdata16 = 16'h1357;
        push_txn(1'b0, 1'b1, 32'h0777, 4'b0011, 32'h1357, 32'h0, -1, 0, 1'b0, 1'b0);
        it        = q[2];
        it.rst    = 1'b1;
        it.drop_w = 1'b1;
        q[2]      = it;
        while (q.size() > 3) void'(q.pop_back());
        for (int s = 0; s < 2; s++) begin
            last_lane[s] = '0;
            last_pad[s]  = '0;
        end
        it        = held(1'b0);
        it.chk_rd = 1'b1;
        it.rdata  = 32'h0;
        q.push_back(it);
        push_idle(1'b0, 3);
        drain(1'b0, "reset_mid");
        @(negedge clk);
        raddr16 = 15'h0003; rreq16 = 2'b01;
        push_txn(1'b0, 1'b0, 32'h0003, 4'b0001, 32'h0, 32'h00E1, -1, 0, 1'b0, 1'b1);
        push_idle(1'b0, 1);
        drain(1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write16();
        test_read16();
        test_wide_wait();
        test_back_to_back();
        test_ena_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_bus_bridge.md
Name: ext_bus_bridge

Overview:
Parametrised bridge between the CPU's split read/write memory ports and the 8-bit multiplexed external bus (address bytes latched by strobes, then byte-serial data). Generalises the existing 16-bit bridge: data width 16/32, configurable address width, sparse byte-lane masks, fixed wait states plus an external wait input. Sits at the top level between `cpu` and the pad ring.

Parameters:
RV, 16, CPU data width in bits; 16 or 32. LB = log2(RV/8) lane-index bits; NL = RV/8 lanes.
AW, 16, external byte-address width; multiple of 8, 8..24. NA = AW/8 address bytes.
WAIT, 0, extra cycles per data beat, 0..7.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ena  in  1  clock enable; low freezes all state and outputs
raddr  in  AW-LB  read word address
rreq  in  NL  read byte-lane mask; nonzero = request
rdata  out  RV  read data, valid while rdone=1
rdone  out  1  one-cycle read completion pulse
waddr  in  AW-LB  write word address
wmask  in  NL  write byte-lane mask; nonzero = request
wdata  in  RV  write data
wdone  out  1  one-cycle write completion pulse
pad_out  out  8  multiplexed address/data byte
pad_in  in  8  external read data byte
latch  out  NA  address-byte strobes; latch[k] captures byte address bits [8k+7:8k]
write  out  1  write strobe for current data beat
lane  out  LB  byte index within word for current data beat
bus_wait  in  1  external stretch; high extends current data beat

Behaviour:
- All outputs registered. Reset: state IDLE, pad_out=0, latch=0, write=0, lane=0, rdata=0, rdone=0, wdone=0. Reset mid-transaction aborts without a done pulse.
- ena=0: no state, counter or output changes (done pulses held, not lost).
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if wmask!=0, capture waddr, wmask, wdata, op=write; else if rreq!=0, capture raddr, rreq, op=read. Write has priority on simultaneous requests. Go to ADDR, driving the first address byte on that edge.
- ADDR: NA cycles, MSB byte first; cycle j drives latch[NA-1-j]=1 (one-hot), pad_out=byte address byte NA-1-j. Byte address = {word addr, LB zeros}. Then DATA.
- DATA: one beat per set mask bit, ascending lane order, unset lanes skipped (mask 4'b1010 -> lanes 1, 3). Beat length 1+WAIT cycles, extended by one cycle for every cycle bus_wait=1 in the beat's final cycle. During beat: lane=index; write op: pad_out=wdata byte, write=1; read op: pad_out holds last address byte, write=0. Read samples pad_in into rdata[8*lane+7:8*lane] at the edge ending the beat.
- After last beat: DONE for one cycle: write=0, latch=0, rdone or wdone=1 for that cycle only; rdata lanes not in rreq read 0 (cleared at capture). Then IDLE.
- Requester holds request until done; requests seen in DONE are ignored, so back-to-back transactions have one IDLE cycle between them.
- Latency from capture edge to done pulse, no bus_wait: NA + popcount(mask)*(1+WAIT) + 1 cycles.

Test Plan:
- RV=16,AW=16,WAIT=0: waddr=0x1234, wmask=2'b11, wdata=0xBEEF -> latch=2'b10 pad 0x24; latch=2'b01 pad 0x68; write=1 lane0 pad 0xEF; write=1 lane1 pad 0xBE; wdone pulse; total 5 cycles.
- Read raddr=0x0010, rreq=2'b10, pad_in=0x5A in beat -> one beat, lane=1; rdone with rdata=0x5A00; rdone high exactly 1 cycle.
- RV=32,AW=24,WAIT=2: wmask=4'b1010, wdata=0x11223344 -> 3 address cycles, beats lane1 pad 0x33 and lane3 pad 0x11, each 3 cycles; wdone 10 cycles after capture.
- Simultaneous wmask=2'b01 and rreq=2'b01 held -> write completes first, one IDLE cycle, then read; bus_wait high 2 cycles in a read beat -> beat +2 cycles, sample taken after release.
- reset asserted in DATA -> next cycle all outputs 0, state IDLE, no done pulse; ena=0 for 3 cycles mid-ADDR -> outputs frozen, sequence resumes unchanged.
